// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Ports: i_clk, i_rst_n (async low), i_halt, i_opcode[6:0], i_imem_ack,
//   i_dmem_ack in; o_imem_req, o_ir_we, o_dec_en, o_alu_en, o_dmem_req,
//   o_dmem_we, o_rf_we, o_pc_we, o_halted, o_illegal, o_timeout, o_state[2:0] out.
// Optional memory-ack timeout: define INSTR_SEQ_MEM_TIMEOUT_EN.
module instr_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_halt,
    input  logic [6:0] i_opcode,
    input  logic       i_imem_ack,
    input  logic       i_dmem_ack,
    output logic       o_imem_req,
    output logic       o_ir_we,
    output logic       o_dec_en,
    output logic       o_alu_en,
    output logic       o_dmem_req,
    output logic       o_dmem_we,
    output logic       o_rf_we,
    output logic       o_pc_we,
    output logic       o_halted,
    output logic       o_illegal,
    output logic       o_timeout,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        C_ALU    = 2'd0,
        C_LOAD   = 2'd1,
        C_STORE  = 2'd2,
        C_BRANCH = 2'd3
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   dec_cls;
    logic   dec_illegal;
    logic   boundary;
    logic   tmo_hit;
    logic   tmo_q;

    always_comb begin
        dec_cls     = C_ALU;
        dec_illegal = 1'b0;
        case (i_opcode)
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b0110011,
            7'b0010011,
            7'b0110111: dec_cls = C_ALU;
            7'b1100011: dec_cls = C_BRANCH;
            default:    dec_illegal = 1'b1;
        endcase
    end

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    logic          tmo_d;

    assign waiting = (state_q == S_FETCH && !i_imem_ack) ||
                     (state_q == S_MEM && !i_dmem_ack);
    assign tmo_hit = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state entry so each wait is bounded alone.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tmo_d = tmo_q | tmo_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_param;

    assign tmo_hit          = 1'b0;
    assign tmo_q            = 1'b0;
    assign unused_tmo_param = (TIMEOUT_CYCLES > 0);
`endif

    // Cycles in which the instruction retires and i_halt is honoured.
    assign boundary = (state_q == S_EXEC && cls_q == C_BRANCH) ||
                      (state_q == S_MEM && i_dmem_ack && cls_q == C_STORE) ||
                      (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_IDLE:   state_d = i_halt ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (i_imem_ack) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD,
                    C_STORE: state_d = S_MEM;
                    C_ALU:   state_d = S_WB;
                    default: state_d = i_halt ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    if (cls_q == C_STORE) begin
                        state_d = i_halt ? S_HALT : S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:     state_d = i_halt ? S_HALT : S_FETCH;
            S_HALT:   state_d = i_halt ? S_HALT : S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_ALU;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_ir_we    = 1'b0;
        o_dec_en   = 1'b0;
        o_alu_en   = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_rf_we    = 1'b0;
        o_pc_we    = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;
        o_timeout  = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_ir_we    = i_imem_ack;
            end
            S_DECODE: o_dec_en = 1'b1;
            S_EXEC: begin
                o_alu_en = 1'b1;
                o_pc_we  = boundary;
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = (cls_q == C_STORE);
                o_pc_we    = boundary;
            end
            S_WB: begin
                o_rf_we = 1'b1;
                o_pc_we = 1'b1;
            end
            S_HALT: o_halted = 1'b1;
            S_TRAP: begin
                o_illegal = !tmo_q;
                o_timeout = tmo_q;
            end
            default: ;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed scoreboard bench for instr_seq_ctrl.
// Expected state/outputs are queued per cycle and popped at the falling edge.
module tb_instr_seq_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_halt;
    logic [6:0] i_opcode;
    logic       i_imem_ack;
    logic       i_dmem_ack;
    logic       o_imem_req, o_ir_we, o_dec_en, o_alu_en;
    logic       o_dmem_req, o_dmem_we, o_rf_we, o_pc_we;
    logic       o_halted, o_illegal, o_timeout;
    logic [2:0] o_state;

    instr_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
        .i_opcode(i_opcode), .i_imem_ack(i_imem_ack),
        .i_dmem_ack(i_dmem_ack), .o_imem_req(o_imem_req),
        .o_ir_we(o_ir_we), .o_dec_en(o_dec_en), .o_alu_en(o_alu_en),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_rf_we(o_rf_we), .o_pc_we(o_pc_we), .o_halted(o_halted),
        .o_illegal(o_illegal), .o_timeout(o_timeout), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2;
    localparam logic [2:0] EXEC = 3'd3, MEM = 3'd4, WB = 3'd5;
    localparam logic [2:0] HALT = 3'd6, TRAP = 3'd7;

    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] IMEM = 11'h400, IRWE = 11'h200;
    localparam logic [10:0] DEN  = 11'h100, ALU  = 11'h080;
    localparam logic [10:0] DREQ = 11'h040, DWE  = 11'h020;
    localparam logic [10:0] RFWE = 11'h010, PCWE = 11'h008;
    localparam logic [10:0] HLT  = 11'h004, ILL  = 11'h002;
    localparam logic [10:0] TMO  = 11'h001;

    localparam logic [6:0] OP_ALU = 7'b0110011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011, OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    wire [13:0] obs = {o_state, o_imem_req, o_ir_we, o_dec_en, o_alu_en,
                       o_dmem_req, o_dmem_we, o_rf_we, o_pc_we,
                       o_halted, o_illegal, o_timeout};

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic [10:0] fl);
        exp_q.push_back({st, fl});
        tag_q.push_back(tag);
    endtask

    task automatic compare_now();
        logic [13:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic cyc(input string tag, input logic h, input logic [6:0] op,
                       input logic ia, input logic da,
                       input logic [2:0] st, input logic [10:0] fl);
        i_halt     = h;
        i_opcode   = op;
        i_imem_ack = ia;
        i_dmem_ack = da;
        expect_out(tag, st, fl);
        @(negedge i_clk);
        compare_now();
        @(posedge i_clk);
        #1;
    endtask

    // Asserts reset in the middle of a cycle and checks outputs drop at once.
    task automatic async_rst(input string tag, input logic [2:0] pre_st,
                             input logic [10:0] pre_fl);
        #1;
        expect_out({tag, "_pre"}, pre_st, pre_fl);
        compare_now();
        i_rst_n = 1'b0;
        #1;
        expect_out(tag, IDLE, NONE);
        compare_now();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_halt     = 1'b0;
        i_opcode   = OP_ALU;
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        expect_out("reset", IDLE, NONE);
        compare_now();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        cyc("idle", 0, OP_ALU, 1, 1, IDLE, NONE);
        for (int k = 0; k < 3; k++) begin
            automatic logic [6:0] op = (k == 0) ? OP_ALU :
                                       (k == 1) ? OP_IMM : OP_LUI;
            cyc("alu_f", 0, op, 1, 1, FETCH, IMEM | IRWE);
            cyc("alu_d", 0, op, 1, 1, DEC, DEN);
            cyc("alu_e", 0, op, 1, 1, EXEC, ALU);
            cyc("alu_w", 0, op, 1, 1, WB, RFWE | PCWE);
        end

        cyc("ld_f", 0, OP_LD, 1, 0, FETCH, IMEM | IRWE);
        cyc("ld_d", 0, OP_LD, 0, 0, DEC, DEN);
        cyc("ld_e", 0, OP_LD, 0, 0, EXEC, ALU);
        for (int k = 0; k < 3; k++) begin
            cyc("ld_wait", 0, OP_LD, 0, 0, MEM, DREQ);
        end
        cyc("ld_ack", 0, OP_LD, 0, 1, MEM, DREQ);
        cyc("ld_w", 0, OP_LD, 0, 0, WB, RFWE | PCWE);

        cyc("st_f", 0, OP_ST, 1, 0, FETCH, IMEM | IRWE);
        cyc("st_d", 0, OP_ST, 0, 0, DEC, DEN);
        cyc("st_e", 0, OP_ST, 0, 0, EXEC, ALU);
        cyc("st_m", 0, OP_ST, 0, 1, MEM, DREQ | DWE | PCWE);

        cyc("br_fw", 0, OP_BR, 0, 1, FETCH, IMEM);
        cyc("br_f", 0, OP_BR, 1, 1, FETCH, IMEM | IRWE);
        cyc("br_d", 0, OP_BR, 0, 0, DEC, DEN);
        cyc("br_e", 0, OP_BR, 0, 0, EXEC, ALU | PCWE);

        cyc("hm_f", 0, OP_ST, 1, 0, FETCH, IMEM | IRWE);
        cyc("hm_d", 0, OP_ST, 0, 0, DEC, DEN);
        cyc("hm_e", 1, OP_ST, 0, 0, EXEC, ALU);
        cyc("hm_mw", 1, OP_ST, 0, 0, MEM, DREQ | DWE);
        cyc("hm_ma", 1, OP_ST, 0, 1, MEM, DREQ | DWE | PCWE);
        cyc("hm_h1", 1, OP_ST, 1, 1, HALT, HLT);
        cyc("hm_h2", 0, OP_ST, 1, 1, HALT, HLT);
        cyc("hm_f2", 0, OP_LD, 1, 0, FETCH, IMEM | IRWE);

        cyc("rm_d", 0, OP_LD, 0, 0, DEC, DEN);
        cyc("rm_e", 0, OP_LD, 0, 0, EXEC, ALU);
        cyc("rm_m", 0, OP_LD, 0, 0, MEM, DREQ);
        async_rst("rst_mem", MEM, DREQ);
        cyc("rm_idle", 0, OP_BAD, 0, 0, IDLE, NONE);

        cyc("il_f", 0, OP_BAD, 1, 0, FETCH, IMEM | IRWE);
        cyc("il_d", 0, OP_BAD, 0, 0, DEC, DEN);
        for (int k = 0; k < 20; k++) begin
            cyc("il_trap", 1'($urandom_range(0, 1)), 7'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                TRAP, ILL);
        end
        async_rst("rst_trap", TRAP, ILL);
        cyc("il_idle", 0, OP_ALU, 0, 0, IDLE, NONE);

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            cyc("to_wait", 0, OP_ALU, 0, 0, FETCH, IMEM);
        end
        cyc("to_trap", 0, OP_ALU, 1, 1, TRAP, TMO);
        cyc("to_hold", 0, OP_ALU, 0, 0, TRAP, TMO);
        async_rst("rst_to", TRAP, TMO);
        cyc("to_idle", 0, OP_ALU, 0, 0, IDLE, NONE);
        for (int k = 0; k < 15; k++) begin
            cyc("to_wait2", 0, OP_ALU, 0, 0, FETCH, IMEM);
        end
        cyc("to_ack16", 0, OP_ALU, 1, 0, FETCH, IMEM | IRWE);
        cyc("to_dec", 0, OP_ALU, 0, 0, DEC, DEN);
`else
        for (int k = 0; k < 20; k++) begin
            cyc("nt_wait", 0, OP_ALU, 0, 0, FETCH, IMEM);
        end
        cyc("nt_ack", 0, OP_ALU, 1, 0, FETCH, IMEM | IRWE);
        cyc("nt_dec", 0, OP_ALU, 0, 0, DEC, DEN);
`endif
        cyc("end_e", 1, OP_ALU, 0, 0, EXEC, ALU);
        cyc("end_w", 1, OP_ALU, 0, 0, WB, RFWE | PCWE);
        cyc("end_h", 1, OP_ALU, 0, 0, HALT, HLT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
